// File: rtl/fibo_host_pkg.sv
// Shared types and constants for the Fibonacci CPU host sequencer.
// Optional feature macro: FIBO_HOST_RANGE_CHECK_EN (request index range check).
package fibo_host_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CPU_RST = 2'd1,
    ST_RUN     = 2'd2,
    ST_DONE    = 2'd3
  } fibo_state_e;

  // Largest index whose Fibonacci value fits in 32 bits
  localparam int unsigned FIBO_MAX_N = 47;

  localparam int unsigned DEF_STABLE_CYCLES  = 64;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1048576;
  localparam int unsigned DEF_RESET_CYCLES   = 4;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/fibo_stable_detect.sv
// Result-stability detector: tracks how long the CPU result word has been unchanged
// and pulses stable when that run length reaches STABLE_CYCLES.
module fibo_stable_detect
  import fibo_host_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_en,
  input  logic        run_en,
  input  logic [31:0] result,
  output logic        stable
);

  localparam logic [31:0] STABLE_W = 32'(STABLE_CYCLES);

  logic [31:0] prev_r;
  logic [31:0] cnt_r;
  logic [31:0] cnt_nxt_s;

  // Next run length of identical samples; outside RUN the count is held at zero
  always_comb begin
    cnt_nxt_s = 32'd0;
    if (run_en && (result == prev_r)) begin
      cnt_nxt_s = sat_inc32(cnt_r);
    end else begin
      cnt_nxt_s = 32'd0;
    end
  end

  assign stable = run_en && (cnt_nxt_s >= STABLE_W);

  // Previous-sample register (also loaded during CPU reset) and stable counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_r <= 32'd0;
      cnt_r  <= 32'd0;
    end else begin
      if (sample_en) begin
        prev_r <= result;
      end
      cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: rtl/fibo_host.sv
// Host sequencer for a Fibonacci CPU core: resets the core, runs it until its
// result word settles or a timeout expires, and returns the value.
// Optional feature macro: FIBO_HOST_RANGE_CHECK_EN (reject req_n > FIBO_MAX_N).
module fibo_host
  import fibo_host_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned RESET_CYCLES   = DEF_RESET_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_n,
  output logic        cpu_reset,
  output logic [31:0] cpu_n,
  output logic        cpu_started,
  input  logic [31:0] cpu_result,
  input  logic        cpu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout,
  output logic        rsp_error,
  output logic [31:0] run_cycles
);

  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] RESET_W   = 32'(RESET_CYCLES);

  fibo_state_e state_r;
  logic [1:0]  rst_sync_r;
  logic        req_ready_r;
  logic        cpu_reset_r;
  logic        cpu_started_r;
  logic [31:0] cpu_n_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_result_r;
  logic        rsp_timeout_r;
  logic [31:0] run_cycles_r;
  logic [31:0] rst_cnt_r;
  logic [31:0] cyc_r;
  logic        dbg_zero_r;

  logic        accept_s;
  logic        range_bad_s;
  logic        stable_s;
  logic        timeout_s;
  logic [31:0] cyc_nxt_s;
  logic [31:0] rst_cnt_nxt_s;
  logic        unused_dbg_s;

  assign accept_s      = (state_r == ST_IDLE) && req_valid && req_ready_r;
  assign cyc_nxt_s     = sat_inc32(cyc_r);
  assign rst_cnt_nxt_s = sat_inc32(rst_cnt_r);
  assign timeout_s     = (cyc_nxt_s >= TIMEOUT_W);

`ifdef FIBO_HOST_RANGE_CHECK_EN
  logic rsp_error_r;

  assign range_bad_s = (req_n > 32'(FIBO_MAX_N));

  // Error flag is decided at acceptance and held through the matching response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_error_r <= 1'b0;
    end else if (accept_s) begin
      rsp_error_r <= range_bad_s;
    end
  end

  assign rsp_error = rsp_error_r;
`else
  assign range_bad_s = 1'b0;
  assign rsp_error   = 1'b0;
`endif

  fibo_stable_detect #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stable (
    .clk      (clk),
    .reset    (reset),
    .sample_en((state_r == ST_CPU_RST) || (state_r == ST_RUN)),
    .run_en   (state_r == ST_RUN),
    .result   (cpu_result),
    .stable   (stable_s)
  );

  // Reset release synchroniser; requests are accepted only once it has filled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  // Zero flag is kept for debug visibility only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbg_zero_r <= 1'b0;
    end else if (state_r == ST_RUN) begin
      dbg_zero_r <= cpu_zero;
    end
  end

  assign unused_dbg_s = dbg_zero_r;

  // Host sequencing FSM; all handshake and CPU control outputs are registered here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      req_ready_r   <= 1'b0;
      cpu_reset_r   <= 1'b1;
      cpu_started_r <= 1'b0;
      cpu_n_r       <= 32'd0;
      rsp_valid_r   <= 1'b0;
      rsp_result_r  <= 32'd0;
      rsp_timeout_r <= 1'b0;
      run_cycles_r  <= 32'd0;
      rst_cnt_r     <= 32'd0;
      cyc_r         <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cpu_reset_r   <= 1'b1;
          cpu_started_r <= 1'b0;
          if (accept_s) begin
            cpu_n_r     <= req_n;
            req_ready_r <= 1'b0;
            rst_cnt_r   <= 32'd0;
            cyc_r       <= 32'd0;
            if (range_bad_s) begin
              state_r       <= ST_DONE;
              rsp_valid_r   <= 1'b1;
              rsp_result_r  <= 32'd0;
              rsp_timeout_r <= 1'b0;
              run_cycles_r  <= 32'd0;
            end else begin
              state_r <= ST_CPU_RST;
            end
          end else begin
            req_ready_r <= rst_sync_r[1];
          end
        end

        ST_CPU_RST: begin
          if (rst_cnt_nxt_s >= RESET_W) begin
            state_r       <= ST_RUN;
            cpu_reset_r   <= 1'b0;
            cpu_started_r <= 1'b1;
            rst_cnt_r     <= 32'd0;
          end else begin
            rst_cnt_r <= rst_cnt_nxt_s;
          end
        end

        ST_RUN: begin
          cyc_r <= cyc_nxt_s;
          // Completion takes priority over a simultaneous timeout
          if (stable_s || timeout_s) begin
            state_r       <= ST_DONE;
            cpu_reset_r   <= 1'b1;
            cpu_started_r <= 1'b0;
            rsp_valid_r   <= 1'b1;
            rsp_result_r  <= cpu_result;
            rsp_timeout_r <= !stable_s;
            run_cycles_r  <= cyc_nxt_s;
          end
        end

        ST_DONE: begin
          if (rsp_ready) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
            req_ready_r <= rst_sync_r[1];
            cyc_r       <= 32'd0;
          end
        end

        default: begin
          state_r       <= ST_IDLE;
          req_ready_r   <= 1'b0;
          cpu_reset_r   <= 1'b1;
          cpu_started_r <= 1'b0;
          rsp_valid_r   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_r;
  assign cpu_reset   = cpu_reset_r;
  assign cpu_started = cpu_started_r;
  assign cpu_n       = cpu_n_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_result  = rsp_result_r;
  assign rsp_timeout = rsp_timeout_r;
  assign run_cycles  = run_cycles_r;

endmodule
